box_plotter: RTL
================

Name: box_plotter

Overview:
- Responder for the draw-FSM's box-paint handshake.
- Accepts a one-cycle `start` carrying a box origin and 9-bit colour, and raster-scans a BOX_W x BOX_H rectangle.
- Emits one pixel write per handshake toward the VGA framebuffer adapter, with clipping at the screen edge.
- Reports `busy` while scanning and a one-cycle `done` when the box is finished.

Parameters:
- BOX_W, 64, box width in pixels (one board column = 64 px).
- BOX_H, 24, box height in pixels (one board row = 24 px).
- SCR_W, 640, screen width; pixels with x >= SCR_W are clipped.
- SCR_H, 480, screen height; pixels with y >= SCR_H are clipped.

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only when busy=0.
- x0  in  10  box origin x, latched on accept.
- y0  in  9  box origin y, latched on accept.
- color  in  9  box colour {R3,G3,B3}, latched on accept.
- busy  out  1  high while a box is being scanned.
- done  out  1  one-cycle pulse, box complete.
- px_x  out  10  pixel x to framebuffer.
- px_y  out  9  pixel y to framebuffer.
- px_color  out  9  pixel colour.
- px_plot  out  1  pixel write valid.
- px_ready  in  1  framebuffer accepts pixel this cycle; tie high if never stalled.

Behaviour:
- Reset (async, immediate): state=IDLE; busy=0, done=0, px_plot=0, px_x=0, px_y=0, px_color=0; counters and latches cleared.
- States: IDLE, SCAN, FIN.
- IDLE:
  - start=1 latches x0/y0/color, clears col=0 and row=0, and moves to SCAN.
  - Next cycle, busy=1 and the first pixel (x0,y0) is presented.
- SCAN:
  - Presents px_x = x0+col (10-bit), px_y = y0+row (9-bit), px_color = latched colour.
  - Computes the sums at 11/10 bits internally; a pixel is on-screen iff x0+col < SCR_W and y0+row < SCR_H.
  - On-screen pixel: px_plot=1; outputs are held stable until px_ready=1. Handshake = px_plot & px_ready, then advance.
  - Off-screen pixel: px_plot=0; advances unconditionally in one cycle.
  - Advance order is row-major: col increments; at col==BOX_W-1 it wraps to 0 and row increments.
  - The advance from (BOX_W-1, BOX_H-1) enters FIN.
- FIN (one cycle): done=1, busy=0, px_plot=0, then IDLE.
  - `done` and `~busy` are coincident, as the draw FSM requires.
- start while busy=1 is ignored; no queueing.
- start in the FIN cycle is also ignored. The requester re-issues once it sees done with busy low; start in IDLE the following cycle is accepted.
- Latency, px_ready held high, no clipping: start at cycle 0, pixels at cycles 1..BOX_W*BOX_H, done at cycle BOX_W*BOX_H+1.
- Inputs x0/y0/color may change after accept without effect.
- Reset mid-scan aborts immediately: no done pulse, plot drops the same instant.
- Fully off-screen box: zero plots, done after BOX_W*BOX_H+1 cycles.

Decomposition:
- Shared package `tetris_pkg` holds:
  - the colour typedef (9-bit RGB333);
  - screen constants SCR_W and SCR_H;
  - cell geometry CELL_W=64 and CELL_H=24;
  - the colour constants BG (0) and PIECE (9'b111_000_111).
- One natural sub-module, `raster_counter`: a col/row counter pair with an `advance` input, a `last` flag, and wrap.
- Clip compare and state machine stay in box_plotter.

Test Plan:
- Basic box:
  - Stimulus: reset, start with x0=0, y0=0, color=9'h1C7, px_ready=1.
  - Required: exactly 1536 plots; first (0,0), last (63,23); all colour 9'h1C7; done single pulse at cycle 1537 with busy=0.
- Backpressure:
  - Stimulus: x0=64, y0=24, px_ready toggling 1-of-3 cycles.
  - Required: 1536 plots, no pixel skipped or duplicated, outputs stable while stalled, done only after the last handshake.
- Clipping:
  - Stimulus: x0=600, y0=470.
  - Required: only x 600..639 and y 470..479 plotted (400 plots), no plot with x>=640 or y>=480, done at cycle 1537.
- Start while busy:
  - Stimulus: second start with colour 0 at cycle 100 of a box.
  - Required: ignored; all 1536 pixels keep the first colour; a single done.
- Reset mid-scan:
  - Stimulus: assert reset at pixel 500.
  - Required: px_plot=0 and busy=0 asynchronously, no done.
  - After release, a new start at (576,456) scans normally: last pixel (639,479).
- Back-to-back:
  - Stimulus: start in the FIN cycle, then start in IDLE the next cycle.
  - Required: the first is ignored, the second is accepted; busy rises one cycle later.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared types and geometry for the tetris display path: colours, screen size,
// board cell size and the plotter state encoding.
package tetris_pkg;

   typedef logic [8:0] color_t;  // {R3,G3,B3}

   localparam int SCR_W  = 640;
   localparam int SCR_H  = 480;
   localparam int CELL_W = 64;
   localparam int CELL_H = 24;

   localparam color_t BG    = 9'd0;
   localparam color_t PIECE = 9'b111_000_111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_FIN
   } plot_state_t;

endpackage

// File: rtl/box_plotter_raster_counter.sv
// Row-major col/row counter pair: col runs 0..W-1, then wraps and bumps row.
// `last` flags the final (W-1, H-1) position of the rectangle.
module raster_counter #(
   parameter int W = 64,
   parameter int H = 24,
   parameter int COL_BITS = $clog2(W),
   parameter int ROW_BITS = $clog2(H)
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic                clear,
   input  logic                advance,
   output logic [COL_BITS-1:0] col,
   output logic [ROW_BITS-1:0] row,
   output logic                last
);

   localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(W - 1);
   localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(H - 1);

   logic [COL_BITS-1:0] col_reg;
   logic [ROW_BITS-1:0] row_reg;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         col_reg <= '0;
         row_reg <= '0;
      end else if (clear) begin
         col_reg <= '0;
         row_reg <= '0;
      end else if (advance) begin
         if (col_reg == COL_LAST) begin
            col_reg <= '0;
            row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
         end else begin
            col_reg <= col_reg + 1'b1;
         end
      end
   end

   assign col  = col_reg;
   assign row  = row_reg;
   assign last = (col_reg == COL_LAST) && (row_reg == ROW_LAST);

endmodule

// File: rtl/box_plotter.sv
// Paints a BOX_W x BOX_H rectangle one pixel per framebuffer handshake,
// skipping pixels that fall off the right/bottom screen edge.
module box_plotter
   import tetris_pkg::*;
#(
   parameter int BOX_W = tetris_pkg::CELL_W,
   parameter int BOX_H = tetris_pkg::CELL_H,
   parameter int SCR_W = tetris_pkg::SCR_W,
   parameter int SCR_H = tetris_pkg::SCR_H
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       start,
   input  logic [9:0] x0,
   input  logic [8:0] y0,
   input  logic [8:0] color,
   output logic       busy,
   output logic       done,
   output logic [9:0] px_x,
   output logic [8:0] px_y,
   output logic [8:0] px_color,
   output logic       px_plot,
   input  logic       px_ready
);

   localparam int COL_BITS = $clog2(BOX_W);
   localparam int ROW_BITS = $clog2(BOX_H);

   plot_state_t state_reg, state_next;
   logic [9:0]  x0_reg;
   logic [8:0]  y0_reg;
   color_t      color_reg;

   logic [COL_BITS-1:0] col;
   logic [ROW_BITS-1:0] row;
   logic                last;
   logic                clear;
   logic                advance;

   // One extra bit on each sum so an overflowing coordinate still reads as off-screen.
   logic [10:0] x_sum;
   logic [9:0]  y_sum;
   logic        on_screen;

   assign x_sum     = {1'b0, x0_reg} + 11'(col);
   assign y_sum     = {1'b0, y0_reg} + 10'(row);
   assign on_screen = (x_sum < 11'(SCR_W)) && (y_sum < 10'(SCR_H));

   raster_counter #(
      .W        (BOX_W),
      .H        (BOX_H),
      .COL_BITS (COL_BITS),
      .ROW_BITS (ROW_BITS)
   ) u_raster (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .clear    (clear),
      .advance  (advance),
      .col      (col),
      .row      (row),
      .last     (last)
   );

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         x0_reg    <= '0;
         y0_reg    <= '0;
         color_reg <= BG;
      end else begin
         state_reg <= state_next;
         if (clear) begin
            x0_reg    <= x0;
            y0_reg    <= y0;
            color_reg <= color;
         end
      end
   end

   // Outputs decode straight from state so an async reset drops plot/busy at once.
   always_comb begin
      state_next = state_reg;
      clear      = 1'b0;
      advance    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      px_plot    = 1'b0;
      px_x       = '0;
      px_y       = '0;
      px_color   = BG;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               clear      = 1'b1;
               state_next = ST_SCAN;
            end
         end
         ST_SCAN: begin
            busy     = 1'b1;
            px_x     = x_sum[9:0];
            px_y     = y_sum[8:0];
            px_color = color_reg;
            px_plot  = on_screen;
            advance  = !on_screen || px_ready;
            if (advance && last) begin
               state_next = ST_FIN;
            end
         end
         ST_FIN: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule
